// File: rtl/bsa_pkg.sv
// Shared definitions for the bit-serial adder sequencer: FSM state encoding
// and the default operand width.
package bsa_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int BSA_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/one_full_adder.sv
// Gate-level one-bit full adder cell, time-shared by the bit-serial sequencer.
module one_full_adder (
   input  logic A,
   input  logic B,
   input  logic Carry_in,
   output logic Sum,
   output logic Carry_out
);

   assign Sum       = A ^ B ^ Carry_in;
   assign Carry_out = (A & B) | (Carry_in & (A ^ B));

endmodule

// File: rtl/bit_serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder built around a single full-adder cell, LSB first.
// Define BSA_OVF_EN to add the registered signed-overflow output out_ovf.
module bit_serial_add_ctrl
   import bsa_pkg::*;
#(
   parameter int WIDTH = BSA_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
`ifdef BSA_OVF_EN
   output logic             out_ovf,
`endif
   output logic             busy
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] aSh;
   logic [WIDTH-1:0] bSh;
   logic [WIDTH-1:0] sSh;
   logic             carry;
   logic [CNT_W-1:0] cnt;
   logic             cellSum;
   logic             cellCout;

   one_full_adder u_cell (
      .A         (aSh[0]),
      .B         (bSh[0]),
      .Carry_in  (carry),
      .Sum       (cellSum),
      .Carry_out (cellCout)
   );

   // The sum and carry registers double as the result outputs; they only
   // move during RUN or on a new accept, so they are stable throughout DONE.
   assign out_sum  = sSh;
   assign out_cout = carry;

   // Sequencer: accept in IDLE, one adder-cell step per RUN cycle, then hold
   // the result in DONE until the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         aSh       <= '0;
         bSh       <= '0;
         sSh       <= '0;
         carry     <= 1'b0;
         cnt       <= '0;
`ifdef BSA_OVF_EN
         out_ovf   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  aSh      <= in_a;
                  bSh      <= in_b;
                  carry    <= in_cin;
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            RUN: begin
               carry <= cellCout;
               sSh   <= {cellSum, sSh[WIDTH-1:1]};
               aSh   <= aSh >> 1;
               bSh   <= bSh >> 1;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) begin
`ifdef BSA_OVF_EN
                  // carry still holds the carry into the MSB on this step
                  out_ovf <= carry ^ cellCout;
`endif
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bit_serial_add_ctrl.sv
// Scoreboard bench for bit_serial_add_ctrl (WIDTH=8); out_ovf is checked when
// BSA_OVF_EN is defined.
module tb_bit_serial_add_ctrl;
   import bsa_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_a;
   logic [7:0] in_b;
   logic       in_cin;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_sum;
   logic       out_cout;
   logic       busy;
`ifdef BSA_OVF_EN
   logic       out_ovf;
`endif

   typedef struct packed {
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } exp_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
      logic       ovf;
   } vec_t;

   exp_t sbQ[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   acceptCyc = 0;
   int   accepted = 0;
   int   produced = 0;
   logic randReady = 1'b0;

   bit_serial_add_ctrl #(.WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
`ifdef BSA_OVF_EN
      .out_ovf   (out_ovf),
`endif
      .busy      (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic waitDrive();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic cin,
                                input logic [7:0] eSum, input logic eCout, input logic eOvf);
      int n = 0;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         waitDrive();
         n++;
      end
      if (!in_ready) begin
         errors++;
         checks++;
         $display("[TB] FAIL acceptTimeout: in_ready stayed 0 for %0d cycles, required 1", n);
         in_valid = 1'b0;
         return;
      end
      acceptCyc = cyc;
      sbQ.push_back('{sum: eSum, cout: eCout, ovf: eOvf});
      accepted++;
      waitDrive();
      in_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n = 0;
      while ((busy || out_valid || sbQ.size() != 0) && n < 500) begin
         waitDrive();
         n++;
      end
      if (n >= 500) begin
         errors++;
         checks++;
         $display("[TB] FAIL idleTimeout: busy=%0d out_valid=%0d pending=%0d, required all 0",
                  busy, out_valid, sbQ.size());
      end
   endtask

   // Monitor: samples on the falling edge, so a transfer seen here completes
   // on the following rising edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid) begin
            checkOutput("readyBusyWhileValid", {30'd0, in_ready, busy}, 32'd1);
            if (out_ready) begin
               if (sbQ.size() == 0) begin
                  errors++;
                  checks++;
                  $display("[TB] FAIL spuriousResult: out_valid=1 sum=0x%0h with no pending operands, required none",
                           out_sum);
               end else begin
                  e = sbQ.pop_front();
                  produced++;
                  checkOutput("sum", {24'd0, out_sum}, {24'd0, e.sum});
                  checkOutput("cout", {31'd0, out_cout}, {31'd0, e.cout});
`ifdef BSA_OVF_EN
                  checkOutput("ovf", {31'd0, out_ovf}, {31'd0, e.ovf});
`endif
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (randReady) out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   localparam int NVEC = 10;
   vec_t vecs [NVEC] = '{
      '{a: 8'h0F, b: 8'h01, cin: 1'b0, sum: 8'h10, cout: 1'b0, ovf: 1'b0},
      '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0},
      '{a: 8'hFF, b: 8'hFF, cin: 1'b1, sum: 8'hFF, cout: 1'b1, ovf: 1'b0},
      '{a: 8'h7F, b: 8'h01, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1},
      '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1},
      '{a: 8'h00, b: 8'h00, cin: 1'b1, sum: 8'h01, cout: 1'b0, ovf: 1'b0},
      '{a: 8'hA5, b: 8'h5A, cin: 1'b0, sum: 8'hFF, cout: 1'b0, ovf: 1'b0},
      '{a: 8'h3C, b: 8'h0F, cin: 1'b1, sum: 8'h4C, cout: 1'b0, ovf: 1'b0},
      '{a: 8'h80, b: 8'h7F, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0},
      '{a: 8'h40, b: 8'h40, cin: 1'b0, sum: 8'h80, cout: 1'b0, ovf: 1'b1}
   };

   initial begin
      int   n;
      logic sawValid;
      logic [7:0] ra, rb;
      logic rc;
      logic [8:0] full;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      out_ready = 1'b1;

      // Reset values, then in_ready rises once reset is released
      waitDrive();
      checkOutput("rstInReady", {31'd0, in_ready}, 32'd0);
      checkOutput("rstOutValid", {31'd0, out_valid}, 32'd0);
      checkOutput("rstSum", {24'd0, out_sum}, 32'd0);
      checkOutput("rstCout", {31'd0, out_cout}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
`ifdef BSA_OVF_EN
      checkOutput("rstOvf", {31'd0, out_ovf}, 32'd0);
`endif
      rst = 1'b0;
      waitDrive();
      checkOutput("inReadyAfterRst", {31'd0, in_ready}, 32'd1);

      // Latency: out_valid first seen 9 cycles after the accept cycle
      applyStimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      checkOutput("busyInRun", {30'd0, busy, in_ready}, 32'd2);
      n = 0;
      while (!out_valid && n < 50) begin
         waitDrive();
         n++;
      end
      checkOutput("latency", cyc - acceptCyc, 32'd9);
      waitIdle();

      applyStimulus(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
      waitIdle();

      // Backpressure: result held while out_ready=0, new operands ignored
      out_ready = 1'b0;
      applyStimulus(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         waitDrive();
         n++;
      end
      in_a     = 8'h33;
      in_b     = 8'h44;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checkOutput("bpValid", {31'd0, out_valid}, 32'd1);
         checkOutput("bpSum", {24'd0, out_sum}, 32'h10);
         checkOutput("bpCout", {31'd0, out_cout}, 32'd0);
         checkOutput("bpInReady", {31'd0, in_ready}, 32'd0);
         waitDrive();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      waitDrive();
      checkOutput("bpReleaseValid", {31'd0, out_valid}, 32'd0);
      checkOutput("bpReleaseIdle", {30'd0, busy, in_ready}, 32'd1);
      waitIdle();

      // Reset in the middle of RUN (cnt=3) discards the transaction
      applyStimulus(8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0);
      waitDrive();
      waitDrive();
      waitDrive();
      rst = 1'b1;
      waitDrive();
      sbQ.delete();
      accepted--;
      checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
      checkOutput("midRstValid", {31'd0, out_valid}, 32'd0);
      checkOutput("midRstInReady", {31'd0, in_ready}, 32'd0);
      rst = 1'b0;
      sawValid = 1'b0;
      for (int i = 0; i < 15; i++) begin
         waitDrive();
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("noValidAfterRst", {31'd0, sawValid}, 32'd0);
      applyStimulus(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
      waitIdle();

      // Directed table with random consumer stalls and input gaps
      randReady = 1'b1;
      for (int i = 0; i < NVEC; i++) begin
         n = int'($urandom_range(0, 2));
         for (int j = 0; j < n; j++) waitDrive();
         applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
      end

      // Random operands with random handshake timing
      for (int i = 0; i < 1000; i++) begin
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rc   = 1'($urandom_range(0, 1));
         full = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
         n = int'($urandom_range(0, 2));
         for (int j = 0; j < n; j++) waitDrive();
         applyStimulus(ra, rb, rc, full[7:0], full[8],
                       (ra[7] == rb[7]) && (full[7] != ra[7]));
      end

      randReady = 1'b0;
      waitDrive();
      out_ready = 1'b1;
      waitIdle();
      waitDrive();
      checkOutput("drained", sbQ.size(), 32'd0);
      checkOutput("countMatch", produced, accepted);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
